// File: rtl/control_path_if.sv
// Handshake and datapath-control bundle between the AEAD control path and
// its neighbours. The master side is the block/data source plus the
// datapath; the slave side is control_path itself.
interface control_path_if;
  // Operation request and block handshakes (driven by the source)
  logic       start;
  logic       ad_empty;
  logic       ad_valid;
  logic       ad_last;
  logic       db_valid;
  logic       db_last;

  // Status and handshake responses (driven by control_path)
  logic       ready;
  logic       ad_ready;
  logic       db_ready;
  logic       dout_valid;
  logic       tag_valid;

  // Datapath controls (driven by control_path)
  logic [3:0] rnd;
  logic       en_internal;
  logic       en_new_aead;
  logic       sel_state;
  logic       sel_din;
  logic       sel_dout;
  logic       sel_xor_data;
  logic       end_ad;
  logic [1:0] sel_xor_key;

  modport master (
    output start, ad_empty, ad_valid, ad_last, db_valid, db_last,
    input  ready, ad_ready, db_ready, dout_valid, tag_valid,
    input  rnd, en_internal, en_new_aead, sel_state, sel_din, sel_dout,
    input  sel_xor_data, end_ad, sel_xor_key
  );

  modport slave (
    input  start, ad_empty, ad_valid, ad_last, db_valid, db_last,
    output ready, ad_ready, db_ready, dout_valid, tag_valid,
    output rnd, en_internal, en_new_aead, sel_state, sel_din, sel_dout,
    output sel_xor_data, end_ad, sel_xor_key
  );
endinterface

// File: rtl/control_path.sv
// Ascon AEAD control path: sequences permutation rounds, absorbs associated
// data (AD) and data blocks (DB), and produces the final tag strobe.
// Optional feature: define ASCON_CTRL_ABORT_EN to add an 'abort' input that
// drops any running operation back to IDLE without producing a tag.
module control_path (
  input  logic         clk,
  input  logic         rst,
`ifdef ASCON_CTRL_ABORT_EN
  input  logic         abort,
`endif
  control_path_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    AD_PERM,
    DB_PERM,
    FINAL
  } state_e;

  localparam logic [3:0] LAST_RND  = 4'd11;
  localparam logic [3:0] PERM_BASE = 4'd4;   // first round of the short (8-round) permutation

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       ade_q, ade_d;           // operation started with no AD blocks
  logic       ad_last_q, ad_last_d;   // most recently absorbed AD block was the final one
  logic       next_is_ad;

  // State, round counter and operation flags; synchronous active-high reset
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values computed by the combinational block.
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ade_q     <= 1'b0;
      ad_last_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ade_q     <= ade_d;
      ad_last_q <= ad_last_d;
    end
  end

  // Next-state and all datapath controls, decoded from state, cnt, flags and handshakes
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d          = state_q;
    cnt_d            = cnt_q;
    ade_d            = ade_q;
    ad_last_d        = ad_last_q;
    bus.ready        = 1'b0;
    bus.ad_ready     = 1'b0;
    bus.db_ready     = 1'b0;
    bus.dout_valid   = 1'b0;
    bus.tag_valid    = 1'b0;
    bus.rnd          = cnt_q;
    bus.en_internal  = 1'b0;
    bus.en_new_aead  = 1'b0;
    bus.sel_state    = 1'b0;
    bus.sel_din      = 1'b0;
    bus.sel_dout     = 1'b0;
    bus.sel_xor_data = 1'b0;
    bus.end_ad       = 1'b0;
    bus.sel_xor_key  = 2'b00;

    // The block awaited at an absorb cycle is AD only while AD blocks remain
    next_is_ad = ((state_q == INIT) && !ade_q) ||
                 ((state_q == AD_PERM) && !ad_last_q);

    unique case (state_q)
      IDLE: begin
        bus.ready = 1'b1;
        if (bus.start) begin
          bus.en_new_aead = 1'b1;
          bus.sel_state   = 1'b1;
          bus.en_internal = 1'b1;
          ade_d           = bus.ad_empty;
          cnt_d           = '0;
          state_d         = INIT;
        end
      end

      INIT, AD_PERM, DB_PERM: begin
        if (cnt_q != LAST_RND) begin
          bus.en_internal = 1'b1;
          cnt_d           = cnt_q + 4'd1;
        end else begin
          // Absorb cycle: the initialisation key XOR applies on the INIT absorb
          if (state_q == INIT) bus.sel_xor_key[0] = 1'b1;

          if (next_is_ad) begin
            if (bus.ad_valid) begin
              bus.en_internal  = 1'b1;
              bus.ad_ready     = 1'b1;
              bus.sel_xor_data = 1'b1;
              ad_last_d        = bus.ad_last;
              cnt_d            = PERM_BASE;
              state_d          = AD_PERM;
            end
          end else if (bus.db_valid) begin
            bus.en_internal  = 1'b1;
            bus.db_ready     = 1'b1;
            bus.dout_valid   = 1'b1;
            bus.sel_xor_data = 1'b1;
            bus.sel_din      = 1'b1;
            // Only DB_PERM follows a data block, so any other state means first DB
            bus.end_ad       = (state_q != DB_PERM);
            if (bus.db_last) begin
              bus.sel_xor_key[1] = 1'b1;
              cnt_d              = '0;
              state_d            = FINAL;
            end else begin
              cnt_d   = PERM_BASE;
              state_d = DB_PERM;
            end
          end
        end
      end

      FINAL: begin
        bus.en_internal = 1'b1;
        if (cnt_q != LAST_RND) begin
          cnt_d = cnt_q + 4'd1;
        end else begin
          bus.sel_xor_key = 2'b01;
          bus.sel_dout    = 1'b1;
          bus.tag_valid   = 1'b1;
          cnt_d           = '0;
          state_d         = IDLE;
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase

`ifdef ASCON_CTRL_ABORT_EN
    // Abort overrides everything: silence handshakes and drop to IDLE
    if (abort && (state_q != IDLE)) begin
      bus.ad_ready    = 1'b0;
      bus.db_ready    = 1'b0;
      bus.dout_valid  = 1'b0;
      bus.tag_valid   = 1'b0;
      bus.en_internal = 1'b0;
      cnt_d           = '0;
      state_d         = IDLE;
    end
`endif
  end

endmodule

// File: tb/tb_control_path.sv
// Self-checking bench for control_path. Each operation is described as a
// sequence of phases (permutation rounds, absorbs with optional stalls, tag),
// expanded into a per-cycle list of inputs and expected outputs.
module tb_control_path;

  logic clk = 1'b0;
  logic rst;

  control_path_if bus ();

  control_path dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       ready;
    logic       en_internal;
    logic       en_new_aead;
    logic       sel_state;
    logic       sel_din;
    logic       sel_dout;
    logic       sel_xor_data;
    logic       end_ad;
    logic [1:0] sel_xor_key;
    logic       ad_ready;
    logic       db_ready;
    logic       dout_valid;
    logic       tag_valid;
    logic [3:0] rnd;
  } out_t;

  typedef struct {
    logic start, ad_empty, ad_valid, ad_last, db_valid, db_last;
    out_t exp;
  } step_t;

  step_t trace[$];
  int    n_total  = 0;
  int    n_passed = 0;
  int    stall_total;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic out_t observe();
    out_t o;
    o.ready        = bus.ready;
    o.en_internal  = bus.en_internal;
    o.en_new_aead  = bus.en_new_aead;
    o.sel_state    = bus.sel_state;
    o.sel_din      = bus.sel_din;
    o.sel_dout     = bus.sel_dout;
    o.sel_xor_data = bus.sel_xor_data;
    o.end_ad       = bus.end_ad;
    o.sel_xor_key  = bus.sel_xor_key;
    o.ad_ready     = bus.ad_ready;
    o.db_ready     = bus.db_ready;
    o.dout_valid   = bus.dout_valid;
    o.tag_valid    = bus.tag_valid;
    o.rnd          = bus.rnd;
    return o;
  endfunction

  // Random "don't care" inputs; outputs must not depend on them in most cycles
  function automatic step_t rnd_step();
    step_t s;
    s.start    = 1'($urandom);
    s.ad_empty = 1'($urandom);
    s.ad_valid = 1'($urandom);
    s.ad_last  = 1'($urandom);
    s.db_valid = 1'($urandom);
    s.db_last  = 1'($urandom);
    s.exp      = '0;
    return s;
  endfunction

  function automatic int pick_stall(int max_stall);
    if (max_stall == 0 || $urandom_range(0, 1) == 0) return 0;
    return int'($urandom_range(1, max_stall));
  endfunction

  // Permutation rounds first..10, each advancing the round index
  task automatic add_rounds(int first);
    step_t s;
    for (int r = first; r <= 10; r++) begin
      s = rnd_step();
      s.exp.en_internal = 1'b1;
      s.exp.rnd         = 4'(r);
      trace.push_back(s);
    end
  endtask

  // Absorb at round 11: 'stalls' cycles without valid, then the consuming cycle
  task automatic add_absorb(bit is_ad, bit last, bit in_init, bit first_db, int stalls);
    step_t s;
    for (int k = 0; k < stalls; k++) begin
      s = rnd_step();
      if (is_ad) s.ad_valid = 1'b0; else s.db_valid = 1'b0;
      s.exp.rnd         = 4'd11;
      s.exp.sel_xor_key = {1'b0, in_init};
      trace.push_back(s);
    end
    stall_total += stalls;
    s = rnd_step();
    s.exp.rnd          = 4'd11;
    s.exp.en_internal  = 1'b1;
    s.exp.sel_xor_data = 1'b1;
    if (is_ad) begin
      s.ad_valid         = 1'b1;
      s.ad_last          = last;
      s.exp.ad_ready     = 1'b1;
      s.exp.sel_xor_key  = {1'b0, in_init};
    end else begin
      s.db_valid         = 1'b1;
      s.db_last          = last;
      s.exp.db_ready     = 1'b1;
      s.exp.dout_valid   = 1'b1;
      s.exp.sel_din      = 1'b1;
      s.exp.end_ad       = first_db;
      s.exp.sel_xor_key  = {last, in_init};
    end
    trace.push_back(s);
  endtask

  // Whole operation with a AD blocks and m data blocks; db0_stall >= 0 forces
  // the stall length on the first data-block absorb
  task automatic build_op(int a, int m, int max_stall, int db0_stall, output int latency);
    step_t s;
    int    st;
    trace.delete();
    stall_total = 0;
    s = rnd_step();
    s.start           = 1'b1;
    s.ad_empty        = (a == 0);
    s.exp.ready       = 1'b1;
    s.exp.en_new_aead = 1'b1;
    s.exp.sel_state   = 1'b1;
    s.exp.en_internal = 1'b1;
    trace.push_back(s);
    add_rounds(0);
    for (int i = 0; i < a; i++) begin
      add_absorb(1'b1, i == a - 1, i == 0, 1'b0, pick_stall(max_stall));
      add_rounds(4);
    end
    for (int j = 0; j < m; j++) begin
      st = (j == 0 && db0_stall >= 0) ? db0_stall : pick_stall(max_stall);
      add_absorb(1'b0, j == m - 1, (a == 0) && (j == 0), j == 0, st);
      if (j != m - 1) add_rounds(4);
    end
    add_rounds(0);
    s = rnd_step();
    s.exp.rnd         = 4'd11;
    s.exp.en_internal = 1'b1;
    s.exp.sel_xor_key = 2'b01;
    s.exp.sel_dout    = 1'b1;
    s.exp.tag_valid   = 1'b1;
    trace.push_back(s);
    for (int k = 0; k < 2; k++) begin
      s = rnd_step();
      s.start     = 1'b0;
      s.exp.ready = 1'b1;
      trace.push_back(s);
    end
    latency = 24 + 8 * a + 8 * (m - 1) + stall_total;
  endtask

  task automatic drive(step_t s);
    bus.start    = s.start;
    bus.ad_empty = s.ad_empty;
    bus.ad_valid = s.ad_valid;
    bus.ad_last  = s.ad_last;
    bus.db_valid = s.db_valid;
    bus.db_last  = s.db_last;
  endtask

  task automatic drive_quiet();
    bus.start    = 1'b0;
    bus.ad_empty = 1'b0;
    bus.ad_valid = 1'b0;
    bus.ad_last  = 1'b0;
    bus.db_valid = 1'b0;
    bus.db_last  = 1'b0;
  endtask

  // Play up to n_max steps; entered and left at posedge+1
  task automatic run_trace(string tag, int n_max, int latency);
    out_t o;
    int   tag_at  = -1;
    int   end_cnt = 0;
    for (int i = 0; i < trace.size() && i < n_max; i++) begin
      drive(trace[i]);
      @(negedge clk);
      o = observe();
      check($sformatf("%s.step%0d", tag, i), 32'(o), 32'(trace[i].exp));
      if (o.tag_valid && tag_at < 0) tag_at = i;
      if (o.end_ad) end_cnt++;
      @(posedge clk);
      #1;
    end
    if (n_max >= trace.size()) begin
      check({tag, ".latency"}, 32'(tag_at), 32'(latency));
      check({tag, ".end_ad_once"}, 32'(end_cnt), 32'd1);
    end
  endtask

  out_t idle_exp;
  int   lat;

  initial begin
    idle_exp       = '0;
    idle_exp.ready = 1'b1;

    rst = 1'b1;
    drive_quiet();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_state", 32'(observe()), 32'(idle_exp));
    @(posedge clk);
    #1;

    // No AD, single final data block: absorb at 12, tag at 24
    build_op(0, 1, 0, 0, lat);
    run_trace("a0m1", trace.size(), lat);

    // One AD block, one data block: tag at 32
    build_op(1, 1, 0, 0, lat);
    run_trace("a1m1", trace.size(), lat);

    // Two AD blocks, three data blocks: tag at 56
    build_op(2, 3, 0, 0, lat);
    run_trace("a2m3", trace.size(), lat);

    // Five-cycle stall on the first data absorb delays the tag by 5
    build_op(1, 2, 0, 5, lat);
    run_trace("stall5", trace.size(), lat);

    // Reset pulse during the first AD permutation
    build_op(2, 1, 0, 0, lat);
    run_trace("pre_rst", 18, lat);
    drive_quiet();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_op_reset", 32'(observe()), 32'(idle_exp));
    @(posedge clk);
    #1;
    build_op(2, 1, 0, 0, lat);
    run_trace("post_rst", trace.size(), lat);

    // Randomised block counts and stall patterns
    for (int t = 0; t < 8; t++) begin
      build_op(int'($urandom_range(0, 3)), int'($urandom_range(1, 3)), 3, -1, lat);
      run_trace($sformatf("rand%0d", t), trace.size(), lat);
    end

    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule
